hex_display_scanner: RTL and testbench



---
 rtl/hex_display_scanner.sv | 131 +++++++++++++
 tb/tb_hex_display_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// -------------------
// Time-multiplexes four hex nibbles (raw data, corrected data, syndrome and
// flags from the Hamming decode top level) onto a 4-digit common-anode
// 7-segment display. All inputs are snapshotted once per frame so a digit can
// never change part-way through a scan. Each digit slot starts with a short
// all-anodes-off window to suppress ghosting between digits.
//
// Ports:
//   clk        board clock (27 MHz)
//   rst        asynchronous reset, active-high
//   digits_in  digit k nibble is digits_in[4k+3:4k]; digit 0 is rightmost
//   blank_in   blank_in[k]=1 forces digit k dark
//   seg        segments {g,f,e,d,c,b,a}, active-low, registered
//   an         anode enables, active-low, an[k] selects digit k, registered
//   digit_idx  index of the slot currently being scanned
//   frame_tick one-cycle pulse on the cycle the snapshot loads

module hex_display_scanner #(
    parameter int CLKS_PER_DIGIT = 27000,
    parameter int BLANK_CLKS     = 270,
    parameter int CNT_W          = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CLKS);

    // Scan state
    logic [CNT_W-1:0] slotCnt_q,   slotCnt_d;
    logic [1:0]       digitIdx_q,  digitIdx_d;

    // Frame snapshot
    logic [15:0]      snapData_q;
    logic [3:0]       snapBlank_q;
    logic             loadPending_q;

    // Registered outputs
    logic [6:0]       seg_q,       seg_d;
    logic [3:0]       an_q,        an_d;
    logic             frameTick_q;

    // Stage-1 intermediates
    logic             slotWrap;
    logic             loadNow;
    logic [3:0]       curNibble;
    logic [6:0]       decoded;
    logic             vis;

    // Full 0-F hex table, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hexDecode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot timing, snapshot load decision and stage-1 decode
    always_comb begin
        slotWrap   = (slotCnt_q == LAST_CNT);
        slotCnt_d  = slotWrap ? '0 : slotCnt_q + CNT_W'(1);
        digitIdx_d = slotWrap ? digitIdx_q + 2'd1 : digitIdx_q;

        // A load either finishes the post-reset handshake or coincides with
        // the wrap into the digit-0 slot, so the new data is used from the
        // very first cycle of that slot.
        loadNow    = loadPending_q || (slotWrap && (digitIdx_q == 2'd3));

        curNibble  = snapData_q[{digitIdx_q, 2'b00} +: 4];
        decoded    = hexDecode(curNibble);
        vis        = (slotCnt_q >= BLANK_END) && !snapBlank_q[digitIdx_q];

        seg_d      = vis ? decoded : 7'b1111111;
        an_d       = vis ? ~(4'b0001 << digitIdx_q) : 4'b1111;
    end

    // All state, including the stage-2 output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotCnt_q     <= '0;
            digitIdx_q    <= 2'd0;
            snapData_q    <= 16'h0000;
            snapBlank_q   <= 4'b1111;
            loadPending_q <= 1'b1;
            seg_q         <= 7'b1111111;
            an_q          <= 4'b1111;
            frameTick_q   <= 1'b0;
        end else begin
            slotCnt_q     <= slotCnt_d;
            digitIdx_q    <= digitIdx_d;
            loadPending_q <= 1'b0;
            frameTick_q   <= loadNow;
            if (loadNow) begin
                snapData_q  <= digits_in;
                snapBlank_q <= blank_in;
            end
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = digitIdx_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner
// ----------------------
// Self-checking bench for hex_display_scanner with CLKS_PER_DIGIT=8 and
// BLANK_CLKS=2. The reference model tracks the number of clock edges since
// reset release and derives slot position, digit index, frame loads and the
// expected display from that count with plain arithmetic.

module tb_hex_display_scanner;

   localparam int CPD   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 4 * CPD;

   logic        clk;
   logic        rst;
   logic [15:0] digitsIn;
   logic [3:0]  blankIn;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [1:0]  digitIdx;
   logic        frameTick;

   int errors;
   int checks;

   // Edges seen since reset release, plus the model's frame snapshot
   int          tick;
   logic [15:0] mSnapData;
   logic [3:0]  mSnapBlank;

   logic [6:0] hexTable [16];

   hex_display_scanner #(
      .CLKS_PER_DIGIT(CPD),
      .BLANK_CLKS    (BLANK),
      .CNT_W         (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .digits_in (digitsIn),
      .blank_in  (blankIn),
      .seg       (seg),
      .an        (an),
      .digit_idx (digitIdx),
      .frame_tick(frameTick)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One compared value
   task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s at tick %0d: observed=%h expected=%h", tag, tick, obs, exp);
      end
   endtask

   // Outputs while reset is applied
   task automatic checkResetState(input string tag);
      checkVal({tag, "_seg"},  16'(seg),       16'h007F);
      checkVal({tag, "_an"},   16'(an),        16'h000F);
      checkVal({tag, "_idx"},  16'(digitIdx),  16'h0000);
      checkVal({tag, "_tick"}, 16'(frameTick), 16'h0000);
   endtask

   // Compare outputs after edge 'tick' against the model, then apply the
   // model's snapshot rule for that edge.
   task automatic checkOutput();
      int         pos;
      int         slotCnt;
      int         dig;
      logic [6:0] expSeg;
      logic [3:0] expAn;
      logic [1:0] expIdx;
      logic       expTick;
      logic [3:0] nib;

      // Outputs after edge t reflect the scan position held before that edge
      pos     = tick - 1;
      slotCnt = pos % CPD;
      dig     = (pos / CPD) % 4;
      expSeg  = 7'b1111111;
      expAn   = 4'b1111;
      if (slotCnt >= BLANK && !mSnapBlank[dig]) begin
         nib       = 4'((mSnapData >> (4 * dig)) & 16'hF);
         expSeg    = hexTable[nib];
         expAn[dig] = 1'b0;
      end
      expIdx  = 2'((tick / CPD) % 4);
      expTick = (tick == 1) || (tick % FRAME == 0);

      checkVal("seg",        16'(seg),       16'(expSeg));
      checkVal("an",         16'(an),        16'(expAn));
      checkVal("digit_idx",  16'(digitIdx),  16'(expIdx));
      checkVal("frame_tick", 16'(frameTick), 16'(expTick));

      if (expTick) begin
         mSnapData  = digitsIn;
         mSnapBlank = blankIn;
      end
   endtask

   // Hold the given inputs for n clock edges, checking after each edge
   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         digitsIn = d;
         blankIn  = b;
         @(posedge clk);
         #1;
         tick++;
         checkOutput();
      end
   endtask

   task automatic modelReset();
      tick       = 0;
      mSnapData  = 16'h0000;
      mSnapBlank = 4'b1111;
   endtask

   initial begin
      logic [15:0] rd;
      logic [3:0]  rb;
      int          guard;

      hexTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      errors   = 0;
      checks   = 0;
      digitsIn = 16'h5A3E;
      blankIn  = 4'b0000;
      modelReset();

      // Power-on reset
      rst = 1'b0;
      #1 rst = 1'b1;
      #10;
      checkResetState("reset");

      // Release: first frame shows E, 3, A, 5
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h5A3E, 4'b0000, FRAME);

      // Snapshot integrity: new data arrives during the digit-1 slot
      applyStimulus(16'h5A3E, 4'b0000, CPD + 2);
      applyStimulus(16'hFFFF, 4'b0000, 3 * CPD - 2);
      applyStimulus(16'hFFFF, 4'b0000, FRAME);

      // Blank mask on digits 0 and 2
      applyStimulus(16'h9C47, 4'b0101, FRAME);
      applyStimulus(16'h9C47, 4'b0101, FRAME);

      // Full decode sweep on digit 0, one value per frame
      for (int v = 0; v < 16; v++) begin
         rd = 16'($urandom);
         rd[3:0] = 4'(v);
         applyStimulus(rd, 4'b0000, FRAME);
      end
      applyStimulus(16'h0000, 4'b0000, FRAME);

      // Random inputs changing every cycle
      for (int i = 0; i < 4 * FRAME; i++) begin
         rd = 16'($urandom);
         rb = 4'($urandom);
         applyStimulus(rd, rb, 1);
      end
      applyStimulus(16'h8D2B, 4'b0000, FRAME);

      // Run into the lit part of the digit-2 slot
      guard = 0;
      while (((tick - 1) % FRAME) != 2 * CPD + 4 && guard < 2 * FRAME) begin
         applyStimulus(16'h8D2B, 4'b0000, 1);
         guard++;
      end
      checkVal("lit_window_reached", 16'(an), 16'b1011);

      // Mid-frame asynchronous reset, sampled before any clock edge
      #2;
      rst = 1'b1;
      #1;
      checkResetState("async_reset");
      @(posedge clk);
      #1;
      checkResetState("reset_hold");

      @(negedge clk);
      rst = 1'b0;
      modelReset();
      applyStimulus(16'h1234, 4'b0000, FRAME + CPD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
